// File: rtl/assoc_dcache.sv
// Set-associative write-back data cache with per-set round-robin victim pointer and halt flush.
// Optional hit counter written out after the flush when DCACHE_HITCOUNT_EN is defined.
module assoc_dcache #(
  parameter int unsigned SETS  = 8,
  parameter int unsigned WAYS  = 2,
  parameter int unsigned WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam int unsigned WOB = $clog2(WORDS);
  localparam int unsigned IW  = $clog2(SETS);
  localparam int unsigned TW  = 32 - 2 - WOB - IW;
  localparam int unsigned WW  = (WORDS > 1) ? WOB : 1;
  localparam int unsigned YW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [31:0] HITCNT_ADDR = 32'h0000_3100;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FETCH,
    FLUSH,
`ifdef DCACHE_HITCOUNT_EN
    CNT,
`endif
    DONE
  } state_t;

  state_t r_state, w_next;

  logic          r_valid [SETS][WAYS];
  logic          r_dirty [SETS][WAYS];
  logic [TW-1:0] r_tag   [SETS][WAYS];
  logic [31:0]   r_data  [SETS][WAYS][WORDS];
  logic [YW-1:0] r_vptr  [SETS];

  logic [WW-1:0] r_word;
  logic [IW-1:0] r_set;
  logic [YW-1:0] r_way;
  logic [TW-1:0] r_mtag;
  logic          r_halt_pend;
`ifdef DCACHE_HITCOUNT_EN
  logic [31:0]   r_hitcnt;
`endif

  logic [TW-1:0] w_tag;
  logic [IW-1:0] w_idx;
  logic [WW-1:0] w_woff;
  logic          w_req, w_hit, w_vdirty, w_hit_wr, w_adv;
  logic [YW-1:0] w_hway, w_vway, w_nway;
  logic [IW-1:0] w_nset;
  logic          w_lastword, w_lastline, w_fdirty;
  logic [1:0]    w_unused_boff;

  function automatic logic [31:0] f_addr(input logic [TW-1:0] t, input logic [IW-1:0] i,
                                         input logic [WW-1:0] w);
    return (32'(t) << (2 + WOB + IW)) | (32'(i) << (2 + WOB)) | (32'(w) << 2);
  endfunction

  assign w_unused_boff = daddr[1:0];
  assign w_woff = WW'((daddr >> 2) & 32'(WORDS - 1));
  assign w_idx  = IW'(daddr >> (2 + WOB));
  assign w_tag  = TW'(daddr >> (2 + WOB + IW));
  assign w_req  = dREN | dWEN;

  // Tag compare and victim choice: lowest invalid way wins, else the set's pointer.
  always_comb begin
    w_hit  = 1'b0;
    w_hway = '0;
    w_vway = r_vptr[w_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit  = 1'b1;
        w_hway = YW'(w);
      end
      if (!r_valid[w_idx][w]) w_vway = YW'(w);
    end
  end

  assign w_vdirty   = r_valid[w_idx][w_vway] & r_dirty[w_idx][w_vway];
  assign w_lastword = (r_word == WW'(WORDS - 1));
  assign w_lastline = (r_set == IW'(SETS - 1)) && (r_way == YW'(WAYS - 1));
  assign w_fdirty   = r_valid[r_set][r_way] & r_dirty[r_set][r_way];
  assign w_nway     = (r_way == YW'(WAYS - 1)) ? '0 : r_way + YW'(1);
  assign w_nset     = (r_way == YW'(WAYS - 1)) ? r_set + IW'(1) : r_set;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    dhit      = 1'b0;
    dmemload  = '0;
    flushed   = 1'b0;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    dmemaddr  = '0;
    dmemstore = '0;
    w_hit_wr  = 1'b0;
    w_adv     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req && w_hit) begin
          dhit     = 1'b1;
          dmemload = r_data[w_idx][w_hway][w_woff];
          w_hit_wr = dWEN;
        end
        if (halt)                 w_next = FLUSH;
        else if (w_req && !w_hit) w_next = w_vdirty ? WB : FETCH;
      end
      WB: begin
        dmemWEN   = 1'b1;
        dmemaddr  = f_addr(r_tag[r_set][r_way], r_set, r_word);
        dmemstore = r_data[r_set][r_way][r_word];
        if (!dwait && w_lastword) w_next = FETCH;
      end
      FETCH: begin
        dmemREN  = 1'b1;
        dmemaddr = f_addr(r_mtag, r_set, r_word);
        if (!dwait && w_lastword) w_next = (halt || r_halt_pend) ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (w_fdirty) begin
          dmemWEN   = 1'b1;
          dmemaddr  = f_addr(r_tag[r_set][r_way], r_set, r_word);
          dmemstore = r_data[r_set][r_way][r_word];
          w_adv     = !dwait && w_lastword;
        end else begin
          w_adv     = 1'b1;
        end
`ifdef DCACHE_HITCOUNT_EN
        if (w_adv && w_lastline) w_next = CNT;
`else
        if (w_adv && w_lastline) w_next = DONE;
`endif
      end
`ifdef DCACHE_HITCOUNT_EN
      CNT: begin
        dmemWEN   = 1'b1;
        dmemaddr  = HITCNT_ADDR;
        dmemstore = r_hitcnt;
        if (!dwait) w_next = DONE;
      end
`endif
      DONE: flushed = 1'b1;
      default: w_next = IDLE;
    endcase
  end

  // Line state, walk counters and miss context.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        r_vptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
        end
      end
      r_word      <= '0;
      r_set       <= '0;
      r_way       <= '0;
      r_mtag      <= '0;
      r_halt_pend <= 1'b0;
`ifdef DCACHE_HITCOUNT_EN
      r_hitcnt    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_word      <= '0;
          r_halt_pend <= 1'b0;
          if (w_hit_wr) r_dirty[w_idx][w_hway] <= 1'b1;
          if (halt) begin
            r_set <= '0;
            r_way <= '0;
          end else if (w_req && !w_hit) begin
            r_set  <= w_idx;
            r_way  <= w_vway;
            r_mtag <= w_tag;
          end
        end
        WB: begin
          if (halt) r_halt_pend <= 1'b1;
          if (!dwait) r_word <= w_lastword ? '0 : r_word + WW'(1);
        end
        FETCH: begin
          if (halt) r_halt_pend <= 1'b1;
          if (!dwait) begin
            r_word <= w_lastword ? '0 : r_word + WW'(1);
            if (w_lastword) begin
              r_valid[r_set][r_way] <= 1'b1;
              r_dirty[r_set][r_way] <= 1'b0;
              r_vptr[r_set] <= (r_vptr[r_set] == YW'(WAYS - 1)) ? '0 : r_vptr[r_set] + YW'(1);
              if (w_next == FLUSH) begin
                r_set <= '0;
                r_way <= '0;
              end
            end
          end
        end
        FLUSH: begin
          if (w_fdirty && !dwait) begin
            r_word <= w_lastword ? '0 : r_word + WW'(1);
            if (w_lastword) r_dirty[r_set][r_way] <= 1'b0;
          end
          if (w_adv) begin
            r_set <= w_nset;
            r_way <= w_nway;
          end
        end
        default: r_word <= '0;
      endcase
`ifdef DCACHE_HITCOUNT_EN
      if (w_hit_wr || (r_state == IDLE && dhit)) r_hitcnt <= r_hitcnt + 32'd1;
`endif
    end
  end

  // Data and tag arrays need no reset; valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (w_hit_wr) r_data[w_idx][w_hway][w_woff] <= dstore;
    if (r_state == FETCH && !dwait) begin
      r_data[r_set][r_way][r_word] <= dload;
      if (w_lastword) r_tag[r_set][r_way] <= r_mtag;
    end
  end

endmodule

// File: tb/tb_assoc_dcache.sv
// Scenario bench for assoc_dcache: memory model, scoreboard of expected memory words, CPU tasks.
// Covers the optional DCACHE_HITCOUNT_EN counter write when that macro is defined.
module tb_assoc_dcache;

  logic        CLK, nRST;
  logic        dREN, dWEN, halt, dwait;
  logic [31:0] daddr, dstore, dload;
  logic        dhit, flushed, dmemREN, dmemWEN;
  logic [31:0] dmemload, dmemaddr, dmemstore;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          errors = 0;
  int          checks = 0;
  int          n_hits = 0;
  int          n_wr   = 0;

  assoc_dcache dut (
    .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dload(dload), .dwait(dwait)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : pat(a);
  endfunction

  function automatic txn_t mk(input bit wr, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.wr = wr; t.addr = a; t.data = d;
    return t;
  endfunction

  // Memory model and scoreboard: each word completing on the bus pops one expectation.
  always @(negedge CLK) begin
    if (nRST) begin
      if (dhit) n_hits++;
      if (dmemREN) dload = mem_rd(dmemaddr);
      if (dmemREN && dmemWEN) begin
        checks++; errors++;
        $display("FAIL bus_exclusive: REN and WEN both high at addr %h", dmemaddr);
      end
      if ((dmemREN || dmemWEN) && !dwait) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_txn: got wr=%0b addr=%h data=%h, none expected",
                   dmemWEN, dmemaddr, dmemstore);
        end else begin
          txn_t e;
          e = exp_q.pop_front();
          if (e.wr !== dmemWEN || e.addr !== dmemaddr || (e.wr && e.data !== dmemstore)) begin
            errors++;
            $display("FAIL mem_txn: got wr=%0b addr=%h data=%h, expected wr=%0b addr=%h data=%h",
                     dmemWEN, dmemaddr, dmemstore, e.wr, e.addr, e.data);
          end
        end
        if (dmemWEN) begin
          mem[dmemaddr] = dmemstore;
          n_wr++;
        end
      end
    end
  end

  task automatic do_reset;
    nRST = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0; dwait = 1'b0;
    daddr = '0; dstore = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    n_hits = 0;
  endtask

  task automatic check_q_empty(input string nm);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected memory words never seen, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic cpu_op(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic [31:0] exp_rd, input string nm);
    int lat;
    bit got;
    @(posedge CLK); #1;
    dREN = !we; dWEN = we; daddr = a; dstore = d;
    lat = 0; got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge CLK);
      if (dhit) got = 1'b1;
      else lat++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no dhit within %0d cycles", nm, lat);
    end else begin
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d cycles, expected %0d", nm, lat, exp_lat);
      end
      if (!we) begin
        checks++;
        if (dmemload !== exp_rd) begin
          errors++;
          $display("FAIL %s_data: got %h, expected %h", nm, dmemload, exp_rd);
        end
      end
    end
    @(posedge CLK); #1;
    dREN = 1'b0; dWEN = 1'b0;
  endtask

  task automatic test_reset;
    nRST = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0; dwait = 1'b0;
    daddr = '0; dstore = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({dhit, flushed, dmemREN, dmemWEN} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got dhit,flushed,REN,WEN=%b, expected 0000",
               {dhit, flushed, dmemREN, dmemWEN});
    end
    checks++;
    if (dmemaddr !== 32'h0 || dmemstore !== 32'h0 || dmemload !== 32'h0) begin
      errors++;
      $display("FAIL reset_buses: got addr=%h store=%h load=%h, expected all zero",
               dmemaddr, dmemstore, dmemload);
    end
    do_reset();
  endtask

  task automatic test_cold_read;
    exp_q.push_back(mk(1'b0, 32'h40, '0));
    exp_q.push_back(mk(1'b0, 32'h44, '0));
    cpu_op(1'b0, 32'h40, '0, 3, pat(32'h40), "cold_rd_40");
    check_q_empty("cold_rd_traffic");
  endtask

  task automatic test_write_hit;
    cpu_op(1'b1, 32'h40, 32'hDEADBEEF, 0, '0, "wr_hit_40");
    cpu_op(1'b0, 32'h40, '0, 0, 32'hDEADBEEF, "rd_back_40");
    cpu_op(1'b0, 32'h44, '0, 0, pat(32'h44), "rd_hit_44");
    cpu_op(1'b1, 32'h41, 32'h1234_5678, 0, '0, "wr_hit_byteoff");
    cpu_op(1'b0, 32'h43, '0, 0, 32'h1234_5678, "rd_byteoff");
    cpu_op(1'b1, 32'h40, 32'hDEADBEEF, 0, '0, "wr_hit_40_again");
    check_q_empty("write_hit_no_traffic");
  endtask

  task automatic test_dirty_evict;
    int lat;
    bit got;
    exp_q.push_back(mk(1'b0, 32'h80, '0));
    exp_q.push_back(mk(1'b0, 32'h84, '0));
    cpu_op(1'b0, 32'h80, '0, 3, pat(32'h80), "fill_80_way1");
    check_q_empty("fill_80_traffic");
    exp_q.push_back(mk(1'b1, 32'h40, 32'hDEADBEEF));
    exp_q.push_back(mk(1'b1, 32'h44, pat(32'h44)));
    exp_q.push_back(mk(1'b0, 32'hC0, '0));
    exp_q.push_back(mk(1'b0, 32'hC4, '0));
    @(posedge CLK); #1;
    dREN = 1'b1; daddr = 32'hC0; dwait = 1'b1;
    @(negedge CLK);
    checks++;
    if (dhit !== 1'b0) begin
      errors++;
      $display("FAIL evict_miss_dhit: got %b, expected 0", dhit);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (!(dmemWEN === 1'b1 && dmemaddr === 32'h40 && dmemstore === 32'hDEADBEEF)) begin
        errors++;
        $display("FAIL wb_stall_hold: cycle %0d got WEN=%b addr=%h data=%h, expected 1 40 deadbeef",
                 i, dmemWEN, dmemaddr, dmemstore);
      end
    end
    @(posedge CLK); #1;
    dwait = 1'b0;
    lat = 4; got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge CLK);
      if (dhit) got = 1'b1;
      else lat++;
    end
    checks++;
    if (!got || lat != 8) begin
      errors++;
      $display("FAIL evict_latency: got hit=%b after %0d cycles, expected hit after 8", got, lat);
    end
    checks++;
    if (dmemload !== pat(32'hC0)) begin
      errors++;
      $display("FAIL evict_data: got %h, expected %h", dmemload, pat(32'hC0));
    end
    @(posedge CLK); #1;
    dREN = 1'b0;
    check_q_empty("evict_traffic");
    cpu_op(1'b0, 32'h80, '0, 0, pat(32'h80), "rd_80_resident");
  endtask

  task automatic test_halt_flush;
    int wr0, cyc;
    cpu_op(1'b1, 32'hC0, 32'h1111_0001, 0, '0, "wr_hit_C0");
    cpu_op(1'b1, 32'h84, 32'h2222_0002, 0, '0, "wr_hit_84");
    exp_q.push_back(mk(1'b1, 32'hC0, 32'h1111_0001));
    exp_q.push_back(mk(1'b1, 32'hC4, pat(32'hC4)));
    exp_q.push_back(mk(1'b1, 32'h80, pat(32'h80)));
    exp_q.push_back(mk(1'b1, 32'h84, 32'h2222_0002));
`ifdef DCACHE_HITCOUNT_EN
    exp_q.push_back(mk(1'b1, 32'h3100, 32'(n_hits)));
`endif
    wr0 = n_wr;
    @(posedge CLK); #1;
    halt = 1'b1;
    cyc = 0;
    while (flushed !== 1'b1 && cyc < 300) begin
      @(negedge CLK);
      cyc++;
    end
    checks++;
    if (flushed !== 1'b1) begin
      errors++;
      $display("FAIL flush_timeout: flushed=%b after %0d cycles, expected 1", flushed, cyc);
    end
    checks++;
`ifdef DCACHE_HITCOUNT_EN
    if (n_wr - wr0 != 5) begin
`else
    if (n_wr - wr0 != 4) begin
`endif
      errors++;
      $display("FAIL flush_wr_count: got %0d memory writes", n_wr - wr0);
    end
    check_q_empty("flush_traffic");
    @(posedge CLK); #1;
    halt = 1'b0; dREN = 1'b1; daddr = 32'hC0;
    repeat (3) @(negedge CLK);
    checks++;
    if (dhit !== 1'b0 || flushed !== 1'b1 || dmemREN !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: got dhit=%b flushed=%b REN=%b, expected 0 1 0",
               dhit, flushed, dmemREN);
    end
    @(posedge CLK); #1;
    dREN = 1'b0;
  endtask

  task automatic test_reset_mid_fetch;
    do_reset();
    exp_q.push_back(mk(1'b0, 32'h40, '0));
    @(posedge CLK); #1;
    dREN = 1'b1; daddr = 32'h40;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (dmemREN !== 1'b1 || dmemaddr !== 32'h40) begin
      errors++;
      $display("FAIL mid_fetch_active: got REN=%b addr=%h, expected 1 40", dmemREN, dmemaddr);
    end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if ({dhit, flushed, dmemREN, dmemWEN} !== 4'b0000 || dmemaddr !== 32'h0 ||
        dmemstore !== 32'h0 || dmemload !== 32'h0) begin
      errors++;
      $display("FAIL mid_fetch_reset: got flags=%b addr=%h store=%h load=%h, expected all zero",
               {dhit, flushed, dmemREN, dmemWEN}, dmemaddr, dmemstore, dmemload);
    end
    dREN = 1'b0;
    check_q_empty("mid_fetch_traffic");
    @(negedge CLK);
    nRST = 1'b1;
    n_hits = 0;
    exp_q.push_back(mk(1'b0, 32'h40, '0));
    exp_q.push_back(mk(1'b0, 32'h44, '0));
    cpu_op(1'b0, 32'h40, '0, 3, 32'hDEADBEEF, "reread_40_miss");
    check_q_empty("reread_traffic");
  endtask

  initial begin
    dload = '0;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_dirty_evict();
    test_halt_flush();
    test_reset_mid_fetch();
    repeat (2) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
